base_packer: RTL and testbench



---
 rtl/base_packer.sv | 111 +++++++++++
 tb/tb_base_packer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/base_packer.sv
// Packs an ASCII nucleotide stream (2 bits per base, 8 bases MSB-first) into 16-bit FIFO words.
// Optional statistics counters are enabled with `define BASE_PACKER_STATS_EN.
module base_packer #(
  parameter logic [1:0] INVALID_CODE = 2'b00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_char,
  input  logic        in_last,
  output logic        in_ready,
  input  logic        buf_full,
  output logic        wr_en,
  output logic [15:0] buf_in,
  output logic        word_last,
  output logic [3:0]  valid_bases,
  output logic        bad_char
`ifdef BASE_PACKER_STATS_EN
  ,
  output logic [31:0] words_out,
  output logic [15:0] bad_count
`endif
);

  typedef enum logic [1:0] {IDLE, FILL, STALL} state_t;

  state_t      state_q, state_n, mode;
  logic [15:0] shift_reg, pend_word, word_n;
  logic [2:0]  base_cnt;
  logic [3:0]  pend_cnt;
  logic        pend, pend_last;
  logic        accept, complete, char_bad;
  logic [1:0]  code;

  // {bad, code}: case-insensitive ACGT map, anything else is flagged
  function automatic logic [2:0] encode(input logic [7:0] c);
    case (c)
      8'h41, 8'h61: encode = 3'b000;
      8'h43, 8'h63: encode = 3'b001;
      8'h47, 8'h67: encode = 3'b010;
      8'h54, 8'h74: encode = 3'b011;
      default:      encode = {1'b1, INVALID_CODE};
    endcase
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // STALL is the live view of a blocked pending word; the register only holds IDLE/FILL
  always_comb begin
    state_n  = state_q;
    mode     = state_q;
    {char_bad, code} = encode(in_char);
    if (pend && buf_full) mode = STALL;
    in_ready = (mode != STALL);
    accept   = in_valid && in_ready;
    complete = accept && ((base_cnt == 3'd7) || in_last);
    word_n   = shift_reg | ({code, 14'b0} >> {base_cnt, 1'b0});
    if (accept) state_n = complete ? IDLE : FILL;
  end

  assign wr_en       = pend && !buf_full;
  assign buf_in      = pend ? pend_word : 16'h0000;
  assign word_last   = pend ? pend_last : 1'b0;
  assign valid_bases = pend ? pend_cnt  : 4'd0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      pend      <= 1'b0;
      pend_word <= 16'h0000;
      pend_cnt  <= 4'd0;
      pend_last <= 1'b0;
      base_cnt  <= 3'd0;
      shift_reg <= 16'h0000;
      bad_char  <= 1'b0;
    end else begin
      state_q  <= state_n;
      bad_char <= accept && char_bad;
      // a completing word may reload the pending slot in the same cycle it drains
      if (wr_en && !complete) pend <= 1'b0;
      if (accept) begin
        if (complete) begin
          pend      <= 1'b1;
          pend_word <= word_n;
          pend_cnt  <= {1'b0, base_cnt} + 4'd1;
          pend_last <= in_last;
          base_cnt  <= 3'd0;
          shift_reg <= 16'h0000;
        end else begin
          shift_reg <= word_n;
          base_cnt  <= base_cnt + 3'd1;
        end
      end
    end
  end

`ifdef BASE_PACKER_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      words_out <= 32'd0;
      bad_count <= 16'd0;
    end else begin
      if (wr_en)    words_out <= words_out + 32'd1;
      if (bad_char) bad_count <= sat_inc16(bad_count);
    end
  end
`endif

endmodule

// File: tb/tb_base_packer.sv
// Testbench for base_packer: directed vector table, hand-written stall/reset/back-to-back
// sequences, and a randomized stream checked against a queue-based word model.
module tb_base_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_char = 8'h00;
  logic        in_last = 1'b0;
  logic        buf_full = 1'b0;
  logic        in_ready, wr_en, word_last, bad_char;
  logic [15:0] buf_in;
  logic [3:0]  valid_bases;
`ifdef BASE_PACKER_STATS_EN
  logic [31:0] words_out;
  logic [15:0] bad_count;
`endif

  base_packer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_char(in_char), .in_last(in_last),
    .in_ready(in_ready), .buf_full(buf_full), .wr_en(wr_en), .buf_in(buf_in),
    .word_last(word_last), .valid_bases(valid_bases), .bad_char(bad_char)
`ifdef BASE_PACKER_STATS_EN
    , .words_out(words_out), .bad_count(bad_count)
`endif
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total = 0;

  typedef struct packed { logic [15:0] w; logic [3:0] n; logic l; } wrec_t;
  typedef struct { string s; logic [15:0] w; logic [3:0] vb; } vec_t;

  wrec_t exp_q[$];
  wrec_t got_q[$];
  logic  mon_en = 1'b0;
  logic  exp_bad = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // 2-bit base value: position in "ACGT" after upper-casing, -1 when not a base
  function automatic int base_val(input byte c);
    string u, ref_s;
    u = " ";
    u[0] = c;
    u = u.toupper();
    ref_s = "ACGT";
    base_val = -1;
    for (int k = 0; k < 4; k++) if (u[0] == ref_s[k]) base_val = k;
  endfunction

  function automatic logic [15:0] code_of(input byte c);
    int v;
    v = base_val(c);
    code_of = (v < 0) ? 16'd0 : 16'(v);
  endfunction

  // Split a read into 8-base words and queue them as the expected write sequence
  task automatic model_read(input string s);
    int len, n;
    wrec_t r;
    len = s.len();
    for (int c = 0; c < len; c += 8) begin
      n = (len - c < 8) ? len - c : 8;
      r.w = 16'd0;
      for (int k = 0; k < n; k++) r.w = r.w | (code_of(s[c+k]) << (14 - 2*k));
      r.n = 4'(n);
      r.l = (c + n == len);
      exp_q.push_back(r);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (wr_en) got_q.push_back({buf_in, valid_bases, word_last});
      chk("rand_bad_char", bad_char, exp_bad);
    end
  end

  always @(posedge clk) exp_bad <= in_valid && in_ready && (base_val(in_char) < 0);

  vec_t tbl[7];

  initial begin
    string s, alpha;
    int acc_ok, budget, nreads, len;

    tbl[0] = '{"ACGTACGT", 16'h1B1B, 4'd8};
    tbl[1] = '{"ggg",      16'hA800, 4'd3};
    tbl[2] = '{"ANGT",     16'h0B00, 4'd4};
    tbl[3] = '{"AC",       16'h1000, 4'd2};
    tbl[4] = '{"T",        16'hC000, 4'd1};
    tbl[5] = '{"xyzT",     16'h0300, 4'd4};
    tbl[6] = '{"acgtacg",  16'h1B18, 4'd7};

    // Reset
    cyc(); cyc();
    @(negedge clk);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_buf_in", buf_in, 0);
    chk("rst_valid_bases", valid_bases, 0);
    chk("rst_word_last", word_last, 0);
    chk("rst_bad_char", bad_char, 0);
    cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    cyc();

    // Directed single-word reads
    foreach (tbl[t]) begin
      s = tbl[t].s;
      for (int i = 0; i < s.len(); i++) begin
        in_valid = 1'b1; in_char = s[i]; in_last = (i == s.len() - 1);
        @(negedge clk);
        chk($sformatf("tbl%0d_in_ready", t), in_ready, 1);
        chk($sformatf("tbl%0d_early_wr", t), wr_en, 0);
        if (i > 0) chk($sformatf("tbl%0d_bad_char", t), bad_char, base_val(s[i-1]) < 0);
        cyc();
      end
      in_valid = 1'b0; in_last = 1'b0;
      @(negedge clk);
      chk($sformatf("tbl%0d_wr_en", t), wr_en, 1);
      chk($sformatf("tbl%0d_buf_in", t), buf_in, tbl[t].w);
      chk($sformatf("tbl%0d_valid_bases", t), valid_bases, tbl[t].vb);
      chk($sformatf("tbl%0d_word_last", t), word_last, 1);
      chk($sformatf("tbl%0d_bad_last", t), bad_char, base_val(s[s.len()-1]) < 0);
      cyc();
      @(negedge clk);
      chk($sformatf("tbl%0d_drained", t), wr_en, 0);
      chk($sformatf("tbl%0d_bad_clear", t), bad_char, 0);
      cyc();
    end

    // Back-pressure on the first word of a 16-base read
    s = "TTTTTTTTCCCCCCCC";
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_char = s[i]; in_last = 1'b0;
      @(negedge clk);
      chk("stall_pre_ready", in_ready, 1);
      cyc();
    end
    buf_full = 1'b1; in_char = s[7];
    @(negedge clk);
    chk("stall_8th_ready", in_ready, 1);
    chk("stall_8th_wr", wr_en, 0);
    cyc();
    in_char = s[8];
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_ready", in_ready, 0);
      chk("stall_wr_en", wr_en, 0);
      chk("stall_buf_in", buf_in, 16'hFFFF);
      cyc();
    end
    buf_full = 1'b0;
    @(negedge clk);
    chk("unstall_wr_en", wr_en, 1);
    chk("unstall_buf_in", buf_in, 16'hFFFF);
    chk("unstall_vb", valid_bases, 8);
    chk("unstall_last", word_last, 0);
    chk("unstall_ready", in_ready, 1);
    cyc();
    for (int i = 9; i < 16; i++) begin
      in_char = s[i]; in_last = (i == 15);
      @(negedge clk);
      chk("stall_second_early", wr_en, 0);
      cyc();
    end
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    chk("stall_second_wr", wr_en, 1);
    chk("stall_second_buf", buf_in, 16'h5555);
    chk("stall_second_vb", valid_bases, 8);
    chk("stall_second_last", word_last, 1);
    cyc();

    // Back-to-back reads
    in_valid = 1'b1; in_char = "A"; in_last = 1'b0; cyc();
    in_char = "C"; in_last = 1'b1; cyc();
    in_char = "T"; in_last = 1'b1;
    @(negedge clk);
    chk("b2b_wr1", wr_en, 1);
    chk("b2b_buf1", buf_in, 16'h1000);
    chk("b2b_vb1", valid_bases, 2);
    chk("b2b_last1", word_last, 1);
    cyc();
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    chk("b2b_wr2", wr_en, 1);
    chk("b2b_buf2", buf_in, 16'hC000);
    chk("b2b_vb2", valid_bases, 1);
    chk("b2b_last2", word_last, 1);
    cyc();
    @(negedge clk);
    chk("b2b_idle", wr_en, 0);
    cyc();

    // Reset in the middle of a word discards it
    s = "ACGTA";
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_char = s[i]; in_last = 1'b0; cyc();
    end
    in_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_wr", wr_en, 0);
    cyc();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_char = "C"; in_last = (i == 7);
      @(negedge clk);
      chk("post_rst_early", wr_en, 0);
      cyc();
    end
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    chk("post_rst_wr", wr_en, 1);
    chk("post_rst_buf", buf_in, 16'h5555);
    chk("post_rst_vb", valid_bases, 8);
    cyc(); cyc();

    // Randomized reads with random back-pressure
    alpha = "ACGTacgtNxn-ACGT";
    mon_en = 1'b1;
    nreads = 30;
    for (int r = 0; r < nreads; r++) begin
      len = $urandom_range(1, 20);
      s = "";
      for (int i = 0; i < len; i++) s = {s, " "};
      for (int i = 0; i < len; i++) s[i] = alpha[$urandom_range(0, 15)];
      model_read(s);
      for (int i = 0; i < len; i++) begin
        in_valid = 1'b1; in_char = s[i]; in_last = (i == len - 1);
        buf_full = ($urandom_range(0, 9) < 3);
        budget = 0;
        acc_ok = 0;
        while (!acc_ok && budget < 100) begin
          @(negedge clk);
          acc_ok = in_ready;
          cyc();
          if (!acc_ok) buf_full = ($urandom_range(0, 9) < 5);
          budget++;
        end
        if (!acc_ok) chk("rand_accept_timeout", 0, 1);
        if ($urandom_range(0, 7) == 0) begin
          in_valid = 1'b0;
          cyc();
        end
      end
    end
    in_valid = 1'b0; in_last = 1'b0; buf_full = 1'b0;
    repeat (4) cyc();
    mon_en = 1'b0;
    chk("rand_word_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("rand_word%0d", i), got_q[i], exp_q[i]);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
